// File: rtl/mfm_write_encoder.sv
// MFM write encoder: accepts bytes on a valid/ready handshake, drives wr_gate and wr_data flux pulses.
// Optional feature macro MFM_CRC_EN adds crc_init/crc ports with CRC-16-CCITT over accepted bytes.
module mfm_write_encoder #(
  parameter int CELL_TICKS = 2,
  parameter int PULSE_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fdc_clk,
  input  logic        wr_en,
  input  logic [7:0]  data_in,
  input  logic        data_sync,
  input  logic        data_valid,
`ifdef MFM_CRC_EN
  input  logic        crc_init,
  output logic [15:0] crc,
`endif
  output logic        data_ready,
  output logic        wr_gate,
  output logic        wr_data,
  output logic        busy,
  output logic        underrun
);

  localparam int TW = (CELL_TICKS > 1) ? $clog2(CELL_TICKS) : 1;
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [15:0]   SYNC_RAW   = 16'h4489;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CELL_TICKS - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  function automatic logic [15:0] mfm_encode(input logic [7:0] d, input logic prev);
    logic [15:0] w;
    logic        p;
    w = 16'h0000;
    p = prev;
    for (int i = 7; i >= 0; i--) begin
      w[2*i+1] = ~(d[i] | p);
      w[2*i]   = d[i];
      p        = d[i];
    end
    return w;
  endfunction

  state_t        state_q, state_d;
  logic          fdc_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   raw_q, raw_d;
  logic          prev_q, prev_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_sync_q, hold_sync_d;
  logic          hold_empty_q, hold_empty_d;
  logic [PW-1:0] pulse_rem_q, pulse_rem_d;
  logic          wr_data_q, wr_data_d;
  logic          wr_gate_q, wr_gate_d;
  logic          busy_q, busy_d;
  logic          underrun_q, underrun_d;
  logic          tick_s, half_s, accept_s, load_s;

  // Next-state logic: cell timing, word shifting, pulse generation and holding register.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    raw_d        = raw_q;
    prev_d       = prev_q;
    hold_d       = hold_q;
    hold_sync_d  = hold_sync_q;
    hold_empty_d = hold_empty_q;
    pulse_rem_d  = pulse_rem_q;
    wr_data_d    = 1'b0;
    wr_gate_d    = wr_gate_q;
    busy_d       = busy_q;
    underrun_d   = underrun_q;
    load_s       = 1'b0;
    tick_s       = fdc_clk & ~fdc_q;
    half_s       = tick_s && (tick_cnt_q == TICK_LAST);
    accept_s     = data_valid & hold_empty_q;

    if (half_s) begin
      tick_cnt_d = {TW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    // A started pulse runs its full width regardless of FSM state.
    if (pulse_rem_q != {PW{1'b0}}) begin
      pulse_rem_d = pulse_rem_q - PW'(1);
      wr_data_d   = 1'b1;
    end else begin
      wr_data_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_en && !hold_empty_q) begin
          load_s     = 1'b1;
          state_d    = ST_SHIFT;
          wr_gate_d  = 1'b1;
          busy_d     = 1'b1;
          tick_cnt_d = {TW{1'b0}};
          underrun_d = 1'b0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (half_s) begin
          raw_d     = {raw_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (raw_q[15]) begin
            wr_data_d   = 1'b1;
            pulse_rem_d = PULSE_LAST;
          end else begin
            wr_data_d   = wr_data_d;
          end
          // Word boundary: next byte, filler word, or stop.
          if (bit_cnt_q == 4'd15) begin
            if (!hold_empty_q) begin
              load_s = 1'b1;
            end else if (wr_en) begin
              raw_d      = mfm_encode(8'h00, prev_q);
              prev_d     = 1'b0;
              underrun_d = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              wr_gate_d   = 1'b0;
              busy_d      = 1'b0;
              prev_d      = 1'b0;
              hold_d      = 8'h00;
              hold_sync_d = 1'b0;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        wr_gate_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase

    if (load_s) begin
      raw_d        = hold_sync_q ? SYNC_RAW : mfm_encode(hold_q, prev_q);
      prev_d       = hold_sync_q | hold_q[0];
      bit_cnt_d    = 4'd0;
      hold_empty_d = 1'b1;
    end else begin
      hold_empty_d = hold_empty_q;
    end

    // Accept after load so a same-cycle load takes the old byte and hold keeps the new one.
    if (accept_s) begin
      hold_d       = data_in;
      hold_sync_d  = data_sync;
      hold_empty_d = 1'b0;
    end else begin
      hold_d       = hold_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      fdc_q        <= 1'b0;
      tick_cnt_q   <= {TW{1'b0}};
      bit_cnt_q    <= 4'd0;
      raw_q        <= 16'h0000;
      prev_q       <= 1'b0;
      hold_q       <= 8'h00;
      hold_sync_q  <= 1'b0;
      hold_empty_q <= 1'b1;
      pulse_rem_q  <= {PW{1'b0}};
      wr_data_q    <= 1'b0;
      wr_gate_q    <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fdc_q        <= fdc_clk;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      raw_q        <= raw_d;
      prev_q       <= prev_d;
      hold_q       <= hold_d;
      hold_sync_q  <= hold_sync_d;
      hold_empty_q <= hold_empty_d;
      pulse_rem_q  <= pulse_rem_d;
      wr_data_q    <= wr_data_d;
      wr_gate_q    <= wr_gate_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  assign data_ready = hold_empty_q;
  assign wr_gate    = wr_gate_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;

`ifdef MFM_CRC_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) begin
        r = {r[14:0], 1'b0} ^ 16'h1021;
      end else begin
        r = {r[14:0], 1'b0};
      end
    end
    return r;
  endfunction

  logic [15:0] crc_q, crc_d;

  // CRC next value; a sync mark is folded in as 0xA1.
  always_comb begin
    crc_d = crc_q;
    if (crc_init) begin
      crc_d = 16'hFFFF;
    end else if (accept_s) begin
      crc_d = crc16_byte(crc_q, data_sync ? 8'hA1 : data_in);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;
`endif

endmodule
